alu_sequencer: RTL
==================

# alu_sequencer

Command-level controller that sequences the 8-bit ALU for the pipelined core. It accepts one ALU command per valid/ready handshake and drives the ALU selects (S_AF, S3, S4, Cin) and the register-file read index. It can repeat a command over up to 8 consecutive registers with carry chaining, which gives multi-byte arithmetic. It also owns the architectural flag register and issues registered write-backs, inserting bubbles on read-after-write hazards.

## Interface
Parameters:
- NREG, 8: register-file depth; register indices wrap modulo NREG; index 0 is R0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted; high only in IDLE.
- cmd_op  in  8  [7:4] ALU function code, [3] S3, [2] S4, [1] dest_rn (1: RN, 0: R0), [0] chain.
- cmd_rn  in  3  base RN index.
- cmd_len  in  3  iteration count minus 1 (1..8 iterations).
- cmd_imm  in  8  immediate, driven to ALU OR2_in.
- cmd_nowb  in  1  flags-only command; suppresses write-back.
- alu_s_af  out  4  ALU function select.
- alu_s3, alu_s4  out  1 each  ALU operand selects.
- alu_cin  out  1  equals flags[1] (C).
- or2_out  out  8  latched cmd_imm.
- rf_rd_addr  out  3  RN read index.
- alu_out_in  in  8  ALU result.
- alu_flags_in  in  4  ALU flags {P,S,C,Z}.
- wb_valid  out  1  register write strobe, one cycle per written byte.
- wb_dst  out  3  write index.
- wb_data  out  8  write data.
- flags  out  4  architectural flags {P(odd parity),S(positive),C,Z}.
- busy  out  1  state != IDLE or wb_valid.

## Operation
- States: IDLE and RUN.
- **IDLE:** cmd_ready=1. ALU outputs are s_af=0, s3=0, s4=0.
  - On cmd_valid, latch op, rn, len, imm and nowb, set idx=0, and go to RUN.
- **RUN:** cmd_ready=0.
  - rf_rd_addr = (rn+idx) mod NREG.
  - Drive s3 and s4 from the latched op.
  - s_af is the latched code, except when chain=1 and idx>0: code 8 becomes A and code 9 becomes B (add/sub with carry).
- **Read set of the current iteration:**
  - index 0 if S3=0;
  - rf_rd_addr if S3=1 or S4=0.
- **Hazard:** wb_valid=1 and wb_dst is in the read set. The register file has no bypass.
  - The cycle becomes a bubble: no state, flag or write-back update, and idx is held.
- **Execute (no hazard):** on the edge,
  - flags ← alu_flags_in, except Z ← alu Z AND old Z when idx>0 (multi-byte zero);
  - if nowb=0: wb_valid←1, wb_dst ← dest_rn ? (rn+idx) mod NREG : 0, wb_data ← alu_out_in;
  - if idx==len, go to IDLE; otherwise idx←idx+1.
- wb_valid is low in every cycle not following an execute with nowb=0.
- alu_cin always reflects the registered C, so carry chains through consecutive iterations.
- **Reset (any state, including mid-command):** on the rst edge,
  - state←IDLE, idx←0, flags←0000, wb_valid←0, wb_dst←0, wb_data←0, or2_out←0;
  - the in-flight command is abandoned, with no further writes.

## Timing
- Command accepted at edge t. Iteration 0 executes in cycle t+1; its write-back is visible in cycle t+2.
- Without hazards, iterations run one per cycle. The last executes in cycle t+1+len, and cmd_ready is high in cycle t+2+len.
- A dest=R0 command with S3=0 costs 2 cycles per iteration after the first (bubble, then execute).
- Consecutive commands never hazard on each other. The next command executes at earliest 2 cycles after the previous last execute, by which point its write has landed.
- After reset release: cmd_ready=1 in the first cycle, and busy=0.

## Test plan
- **Reset:** hold rst 2 cycles mid-RUN of a len=7 command. Required: next cycle IDLE, flags=0000, wb_valid=0, no writes afterward, cmd_ready=1.
- **Single add:** R0=0x3C, op=0x84 (ADD_AB, S3=0, S4=1, dest R0), imm=0xC4, len=0. Required:
  - s_af=8 in t+1;
  - wb_valid in t+2 with dst=0, data=0x00;
  - flags=0111.
- **16-bit chain:** R1=0xFF, R2=0x00, op=0x8F (ADD_AB, S3=1, S4=1, dest RN, chain), rn=1, imm=0x01, len=1. Required:
  - s_af=8, then A;
  - writes R1=0x00 (t+2) and R2=0x02 (t+3);
  - flags=1100, with Z accumulated to 0.
- **Hazard:** R0=0x10, op=0x44 (INC_A, dest R0), len=2. Required:
  - executes in t+1, t+3, t+5, with bubbles t+2 and t+4;
  - writes 0x11, 0x12, 0x13;
  - cmd_ready high at t+6.
- **Compare:** R0=0x05, op=0x94, imm=0x05, nowb=1. Required: wb_valid never asserted, flags=0101.
- **Handshake:** cmd_valid held high across two commands. Required: the second is accepted only when cmd_ready=1, and neither is lost nor duplicated.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command, ALU-select, register-file and write-back bundle for alu_sequencer
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [2:0] cmd_rn;
    logic [2:0] cmd_len;
    logic [7:0] cmd_imm;
    logic       cmd_nowb;

    logic [3:0] alu_s_af;
    logic       alu_s3;
    logic       alu_s4;
    logic       alu_cin;
    logic [7:0] or2_out;
    logic [2:0] rf_rd_addr;
    logic [7:0] alu_out_in;
    logic [3:0] alu_flags_in;

    logic       wb_valid;
    logic [2:0] wb_dst;
    logic [7:0] wb_data;
    logic [3:0] flags;
    logic       busy;

    // Core side: offers commands, returns ALU results, consumes write-backs
    modport master (
        output cmd_valid, cmd_op, cmd_rn, cmd_len, cmd_imm, cmd_nowb,
        output alu_out_in, alu_flags_in,
        input  cmd_ready, alu_s_af, alu_s3, alu_s4, alu_cin, or2_out, rf_rd_addr,
        input  wb_valid, wb_dst, wb_data, flags, busy
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_rn, cmd_len, cmd_imm, cmd_nowb,
        input  alu_out_in, alu_flags_in,
        output cmd_ready, alu_s_af, alu_s3, alu_s4, alu_cin, or2_out, rf_rd_addr,
        output wb_valid, wb_dst, wb_data, flags, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ALU command sequencer with multi-byte carry chaining, flags and hazard bubbles
module alu_sequencer #(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] NREG_W = 4'(NREG);

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [2:0] rn_q, rn_d;
    logic [2:0] len_q, len_d;
    logic [7:0] imm_q, imm_d;
    logic       nowb_q, nowb_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] flags_q, flags_d;
    logic       wb_valid_q, wb_valid_d;
    logic [2:0] wb_dst_q, wb_dst_d;
    logic [7:0] wb_data_q, wb_data_d;

    logic [3:0] sum;
    logic [2:0] rd_idx;
    logic [3:0] s_af;
    logic       hit_r0;
    logic       hit_rn;
    logic       hazard;
    logic       execute;

    // Operand addressing, chained opcode substitution and RAW hazard detection
    always_comb begin
        sum    = {1'b0, rn_q} + {1'b0, idx_q};
        rd_idx = 3'(sum % NREG_W);
        s_af   = op_q[7:4];
        if (op_q[0] && (idx_q != 3'd0)) begin
            if (op_q[7:4] == 4'h8) s_af = 4'hA;
            if (op_q[7:4] == 4'h9) s_af = 4'hB;
        end
        // The register file has no bypass: a pending write to any register this
        // iteration reads must drain before the iteration can execute.
        hit_r0  = !op_q[3] && (wb_dst_q == 3'd0);
        hit_rn  = (op_q[3] || !op_q[2]) && (wb_dst_q == rd_idx);
        hazard  = (state_q == RUN) && wb_valid_q && (hit_r0 || hit_rn);
        execute = (state_q == RUN) && !hazard;
    end

    // Next-state: command capture in IDLE, iteration execute / bubble in RUN
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rn_d       = rn_q;
        len_d      = len_q;
        imm_d      = imm_q;
        nowb_d     = nowb_q;
        idx_d      = idx_q;
        flags_d    = flags_q;
        wb_valid_d = 1'b0;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    rn_d    = bus.cmd_rn;
                    len_d   = bus.cmd_len;
                    imm_d   = bus.cmd_imm;
                    nowb_d  = bus.cmd_nowb;
                    idx_d   = 3'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (execute) begin
                    // Z accumulates across bytes so a multi-byte result is zero only if every byte is.
                    flags_d[3:1] = bus.alu_flags_in[3:1];
                    flags_d[0]   = (idx_q != 3'd0) ? (bus.alu_flags_in[0] & flags_q[0])
                                                   : bus.alu_flags_in[0];
                    if (!nowb_q) begin
                        wb_valid_d = 1'b1;
                        wb_dst_d   = op_q[1] ? rd_idx : 3'd0;
                        wb_data_d  = bus.alu_out_in;
                    end
                    if (idx_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset that abandons any in-flight command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 8'h00;
            rn_q       <= 3'd0;
            len_q      <= 3'd0;
            imm_q      <= 8'h00;
            nowb_q     <= 1'b0;
            idx_q      <= 3'd0;
            flags_q    <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_dst_q   <= 3'd0;
            wb_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rn_q       <= rn_d;
            len_q      <= len_d;
            imm_q      <= imm_d;
            nowb_q     <= nowb_d;
            idx_q      <= idx_d;
            flags_q    <= flags_d;
            wb_valid_q <= wb_valid_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.alu_s_af   = (state_q == RUN) ? s_af : 4'h0;
    assign bus.alu_s3     = (state_q == RUN) ? op_q[3] : 1'b0;
    assign bus.alu_s4     = (state_q == RUN) ? op_q[2] : 1'b0;
    assign bus.alu_cin    = flags_q[1];
    assign bus.or2_out    = imm_q;
    assign bus.rf_rd_addr = rd_idx;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_dst     = wb_dst_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.flags      = flags_q;
    assign bus.busy       = (state_q != IDLE) || wb_valid_q;

endmodule
